alu_result_acc: RTL and testbench
=================================

# alu_result_acc

Downstream consumer of the 2-operand ALU's signed 5-bit result `C`. It accepts one ALU result per valid cycle and sums results into a signed accumulator, saturating or wrapping. After every GROUP results, or on an explicit flush, it pushes the group sum and a sticky saturation flag into a small output FIFO with a ready/valid drain port. It decouples the ALU's one-result-per-cycle stream from a slower result sink.

## Interface
- `GROUP`, 4, number of accepted results per group sum (2..16)
- `ACC_W`, 8, accumulator width in bits (≥6)
- `DEPTH`, 4, output FIFO entries (power of 2, ≥2)

- `clk`  input  1  single clock, rising edge
- `reset`  input  1  synchronous, active-high
- `in_valid`  input  1  `C` carries a valid ALU result this cycle
- `in_ready`  output  1  block can accept a result this cycle
- `C`  input  5  signed ALU result, range -16..+15
- `flush`  input  1  push the partial group now
- `acc_clear`  input  1  discard the partial group
- `out_valid`  output  1  FIFO head valid
- `out_ready`  input  1  sink takes the head this cycle
- `out_data`  output  ACC_W+1  {sat, sum[ACC_W-1:0]} of the FIFO head
- `group_cnt`  output  5  results accumulated in the current partial group

## Operation
- Accept = `in_valid && in_ready`. `in_ready = !fifo_full`, a registered state; no combinational path from `out_ready`.
- Per accept:
  - `next = acc + sext(C)`, computed ACC_W+1 bits wide.
  - Out-of-range results are clamped or wrapped per Configuration; clamping sets sticky `sat`.
- FSM states:
  - IDLE (`group_cnt`=0).
  - ACC (0 < `group_cnt` < GROUP).
- Transitions:
  - IDLE→ACC on accept when GROUP>1.
  - ACC→ACC on accept with `group_cnt+1` < GROUP.
  - ACC→IDLE on accept that completes the group. {sat, next} is pushed; `acc`, `sat` and `group_cnt` are cleared.
  - ACC→IDLE on `flush` with FIFO not full. The push includes any same-cycle accepted result.
- `flush` in IDLE with no accept: no push. `flush` with FIFO full: ignored, with no state change. The sender must hold `flush` until it takes effect.
- `acc_clear` has highest priority:
  - Zeroes `acc`, `sat` and `group_cnt`, and returns the FSM to IDLE.
  - A same-cycle accepted result is discarded.
  - The FIFO is untouched.
- Opcode-independent: every result `C` is summed identically.
- FIFO:
  - Circular, with read/write pointers and a count of width log2(DEPTH)+1.
  - Pop = `out_valid && out_ready`.
  - Simultaneous push and pop when non-empty: count unchanged.
  - Pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, `out_data`=0, `group_cnt`=0.
  - `acc`=0, `sat`=0, FIFO empty, FSM=IDLE.
- Reset mid-group or with a full FIFO drops all state within one cycle. No push occurs on the reset cycle.
- Latency: group-completing accept at edge N → `out_valid`=1 after edge N, when the FIFO was empty. `out_data` is driven from the head register, not a bypass.
- `in_ready` falls in the cycle after the push that fills the FIFO. It rises in the cycle after the first pop.
- `out_valid`/`out_data` are held stable while `out_ready`=0.

## Configuration
- `ALU_ACC_SAT_EN` defined:
  - Results above 2^(ACC_W-1)-1 clamp to that value.
  - Results below -2^(ACC_W-1) clamp to that value.
  - Either clamp sets `sat` for the rest of the group.
- `ALU_ACC_SAT_EN` undefined:
  - Two's-complement wrap to ACC_W bits.
  - `sat` is constant 0 and `out_data[ACC_W]` is tied 0.

## Test plan
- Reset, then accept 3, -2, 15, -16 back-to-back (GROUP=4) → one push; next cycle `out_valid`=1, `out_data`=9'h000; `group_cnt` 1,2,3,0.
- GROUP=16, sixteen accepts of +15:
  - With `ALU_ACC_SAT_EN`: `out_data`={1, 8'sd127}.
  - Without it: `out_data`={0, 8'hF0} (240 wraps to -16).
- `out_ready`=0, four full groups of +1 → FIFO full, `in_ready`=0 the cycle after the 4th push, and a 5th-group input stalls. One pop → `in_ready`=1 next cycle. Drain order is 4,4,4,4.
- Accept 5, 7, then `flush` → push `out_data`=12; `flush` in IDLE → no push. `flush` with an accept of 3 in the same cycle after 5 → pushes 8.
- Accept 6, then `acc_clear` with `in_valid`=1, `C`=4 → `group_cnt`=0, no push. Then four accepts of 1 → `out_data`=4.
- FIFO holding 2 entries, partial group of 2: assert `reset` one cycle → `out_valid`=0, `group_cnt`=0, `in_ready`=1 after the edge.

Source files
------------

// File: rtl/alu_result_acc.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_acc
// Purpose  : Sums signed 5-bit ALU results into an ACC_W-bit accumulator in
//            groups of GROUP results (or on flush) and queues each group sum,
//            with a sticky saturation flag, in a DEPTH-entry output FIFO.
// Macro    : ALU_ACC_SAT_EN - when defined, sums clamp at the signed
//            ACC_W-bit limits and set a sticky sat flag; otherwise they wrap
//            and the sat bit is tied 0.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            in_valid/in_ready - result handshake (in_ready registered)
//            C                 - signed ALU result, -16..+15
//            flush             - push the partial group now
//            acc_clear         - discard the partial group (highest priority)
//            out_valid/out_ready/out_data - FIFO drain, data = {sat, sum}
//            group_cnt         - results held in the current partial group
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_acc #(
  parameter int GROUP = 4,
  parameter int ACC_W = 8,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic signed [4:0] C,
  input  logic              flush,
  input  logic              acc_clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W:0]    out_data,
  output logic [4:0]        group_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [4:0]     c_last = 5'(GROUP - 1);
  localparam logic [PTR_W:0] c_full = (PTR_W + 1)'(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

  state_t                  r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_acc_next;
  logic                    w_sat_next;
  logic [4:0]              r_cnt;

  logic [ACC_W:0]          r_mem [DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [PTR_W:0]          r_count;
  logic [PTR_W:0]          w_count_next;
  logic                    r_full;
  logic                    r_valid;

  logic                    w_accept;
  logic                    w_group_done;
  logic                    w_flush_go;
  logic                    w_push;
  logic                    w_pop;
  logic [ACC_W:0]          w_push_data;

  // in_ready comes straight from a flop, so there is no path from out_ready.
  assign w_accept     = in_valid && !r_full;
  assign w_group_done = w_accept && (r_cnt == c_last);
  // A flush only pushes when there is something to push: either a partial
  // group already held or a result accepted in the same cycle.
  assign w_flush_go   = flush && !r_full && ((r_state == S_ACC) || w_accept);
  assign w_push       = !acc_clear && (w_group_done || w_flush_go);
  assign w_pop        = r_valid && out_ready;
  assign w_push_data  = {w_sat_next, w_acc_next};

`ifdef ALU_ACC_SAT_EN
  localparam logic signed [ACC_W:0] c_acc_max = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] c_acc_min = {2'b11, {(ACC_W-1){1'b0}}};

  logic               r_sat;
  logic signed [ACC_W:0] w_sum;

  // One extra bit of headroom so the clamp comparison sees the true sum.
  always_comb begin
    w_sum      = {r_acc[ACC_W-1], r_acc} + {{(ACC_W-4){C[4]}}, C};
    w_acc_next = r_acc;
    w_sat_next = r_sat;
    if (w_accept) begin
      if (w_sum > c_acc_max) begin
        w_acc_next = c_acc_max[ACC_W-1:0];
        w_sat_next = 1'b1;
      end else if (w_sum < c_acc_min) begin
        w_acc_next = c_acc_min[ACC_W-1:0];
        w_sat_next = 1'b1;
      end else begin
        w_acc_next = w_sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || acc_clear || w_push) begin
      r_sat <= 1'b0;
    end else begin
      r_sat <= w_sat_next;
    end
  end
`else
  // Plain two's-complement wrap; the sat bit never sets.
  always_comb begin
    w_acc_next = r_acc;
    if (w_accept) begin
      w_acc_next = r_acc + {{(ACC_W-5){C[4]}}, C};
    end
  end

  assign w_sat_next = 1'b0;
`endif

  // Group FSM: IDLE holds no partial sum, ACC holds 1..GROUP-1 results.
  always_ff @(posedge clk) begin
    if (reset || acc_clear || w_push) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_state <= S_ACC;
      r_acc   <= w_acc_next;
      r_cnt   <= r_cnt + 5'd1;
    end
  end

  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + (PTR_W + 1)'(1);
      2'b01:   w_count_next = r_count - (PTR_W + 1)'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == c_full);
      r_valid <= (w_count_next != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  assign in_ready  = !r_full;
  assign out_valid = r_valid;
  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign out_data  = r_valid ? r_mem[r_rd_ptr] : '0;
  assign group_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_result_acc
// Purpose  : Self-checking bench for alu_result_acc. A reference model of
//            group sums feeds an expected-value queue; a monitor pops and
//            compares on every output handshake. A second instance with
//            GROUP=16 covers the long-group overflow case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_acc;

  localparam int GROUP = 4;
  localparam int ACC_W = 8;
  localparam int DEPTH = 4;
  localparam int HI    = (1 << (ACC_W - 1)) - 1;
  localparam int LO    = -(1 << (ACC_W - 1));

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic signed [4:0] C;
  logic              flush;
  logic              acc_clear;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W:0]    out_data;
  logic [4:0]        group_cnt;

  logic              in_valid16;
  logic              in_ready16;
  logic signed [4:0] c16;
  logic              out_valid16;
  logic [ACC_W:0]    out_data16;
  logic [4:0]        group_cnt16;

  always #5 clk = ~clk;

  alu_result_acc #(.GROUP(GROUP), .ACC_W(ACC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .C(C), .flush(flush), .acc_clear(acc_clear), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .group_cnt(group_cnt)
  );

  alu_result_acc #(.GROUP(16), .ACC_W(ACC_W), .DEPTH(DEPTH)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
    .C(c16), .flush(1'b0), .acc_clear(1'b0), .out_valid(out_valid16),
    .out_ready(1'b0), .out_data(out_data16), .group_cnt(group_cnt16)
  );

  int             n_checks = 0;
  int             n_fail   = 0;
  logic [ACC_W:0] exp_q [$];

  // Reference model state: running group sum, results in group, sticky
  // flag, and FIFO occupancy as the sink should see it.
  int m_sum;
  int m_n;
  bit m_sat;
  int m_cnt;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  function automatic void add_result(inout int s, inout bit st, input int c);
    s = s + c;
`ifdef ALU_ACC_SAT_EN
    if (s > HI) begin
      s  = HI;
      st = 1'b1;
    end else if (s < LO) begin
      s  = LO;
      st = 1'b1;
    end
`else
    if (s > HI) s = s - (1 << ACC_W);
    else if (s < LO) s = s + (1 << ACC_W);
`endif
  endfunction

  // One clock: check visible state, drive inputs, advance the model, clock.
  task automatic step(input bit v, input int c, input bit f, input bit clr,
                      input bit ordy);
    bit acc;
    bit push;
    bit pop;
    chk("in_ready", int'(in_ready), int'(m_cnt != DEPTH));
    chk("out_valid", int'(out_valid), int'(m_cnt != 0));
    chk("group_cnt", int'(group_cnt), m_n);
    in_valid  = v;
    C         = 5'(c);
    flush     = f;
    acc_clear = clr;
    out_ready = ordy;
    acc  = v && (m_cnt != DEPTH);
    pop  = (m_cnt != 0) && ordy;
    push = 1'b0;
    if (clr) begin
      m_sum = 0; m_n = 0; m_sat = 1'b0;
    end else begin
      if (acc) begin
        add_result(m_sum, m_sat, c);
        m_n++;
      end
      if ((acc && m_n == GROUP) || (f && m_cnt != DEPTH && m_n > 0)) begin
        exp_q.push_back({m_sat, ACC_W'(m_sum)});
        push  = 1'b1;
        m_sum = 0; m_n = 0; m_sat = 1'b0;
      end
    end
    m_cnt = m_cnt + int'(push) - int'(pop);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    in_valid   = 1'b0;
    C          = '0;
    flush      = 1'b0;
    acc_clear  = 1'b0;
    out_ready  = 1'b0;
    in_valid16 = 1'b0;
    c16        = '0;
    m_sum = 0; m_n = 0; m_sat = 1'b0; m_cnt = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("out_data_reset", int'(out_data), 0);
  endtask

  // Monitor: compares the FIFO head whenever the sink takes it.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop: got unexpected output 0x%0h, expected none", out_data);
      end else begin
        chk("out_data", int'(out_data), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int s16;
    bit st16;

    do_reset();

    // Group of four summing to zero, then drain it.
    step(1, 3, 0, 0, 0);
    step(1, -2, 0, 0, 0);
    step(1, 15, 0, 0, 0);
    step(1, -16, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // Four groups of +1 fill the FIFO; the fifth group stalls.
    for (int i = 0; i < 16; i++) step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);

    // Flush a partial group, flush while idle, flush with same-cycle accept.
    step(1, 5, 0, 0, 1);
    step(1, 7, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    step(1, 5, 0, 0, 1);
    step(1, 3, 1, 0, 1);
    step(0, 0, 0, 0, 1);

    // Clear discards the partial group and a same-cycle result.
    step(1, 6, 0, 0, 1);
    step(1, 4, 0, 1, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Two queued entries plus a partial group, then reset.
    for (int i = 0; i < 10; i++) step(1, 2, 0, 0, 0);
    do_reset();
    step(0, 0, 0, 0, 1);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, int'($urandom_range(0, 31)) - 16,
           $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 9) < 4);
    end
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1);
    chk("queue_empty", exp_q.size(), 0);

    // GROUP=16 instance: sixteen results of +15.
    do_reset();
    s16  = 0;
    st16 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      add_result(s16, st16, 15);
      in_valid16 = 1'b1;
      c16        = 5'sd15;
      @(posedge clk);
      #1;
    end
    in_valid16 = 1'b0;
    chk("g16_out_valid", int'(out_valid16), 1);
    chk("g16_out_data", int'(out_data16), int'({st16, ACC_W'(s16)}));
    chk("g16_group_cnt", int'(group_cnt16), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
